// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one single-port memory between fetch and MEM stage.
// Serialises accesses, drives the pipeline stall, and flags a hung bus.
module pipe_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          bus_err,
    output logic          ram_req,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic          ram_ack
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEM_BUSY,
        IF_BUSY,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;
    logic          err_q, err_d;
    logic          if_done_q, if_done_d;
    logic          mem_done_q, mem_done_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          mem_pend;
    logic          mem_need;
    logic          if_need;

    // Outstanding work this cycle group; MEM is the older instruction.
    always_comb begin
        mem_pend = mem_rd | mem_wr;
        mem_need = mem_pend & ~mem_done_q;
        if_need  = if_req & ~if_done_q;
        stall    = mem_need | if_need | err_q;
    end

    // Next-state and next register values for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        err_d       = err_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (mem_need) begin
                    state_d = MEM_BUSY;
                    req_d   = 1'b1;
                    we_d    = mem_wr;
                    addr_d  = mem_addr;
                    wdata_d = mem_wr ? mem_wdata : '0;
                    cnt_d   = '0;
                end else if (if_need) begin
                    state_d = IF_BUSY;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    cnt_d   = '0;
                end
            end
            MEM_BUSY, IF_BUSY: begin
                if (ram_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (state_q == MEM_BUSY) begin
                        mem_done_d = 1'b1;
                        if (!we_q) begin
                            mem_rdata_d = ram_rdata;
                        end
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = ram_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR: begin
                req_d = 1'b0;
            end
        endcase

        // Pipeline advances: the next cycle group starts with fresh flags.
        if (!stall) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
        end
    end

    // State and bus registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            err_q       <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            err_q       <= err_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ram_req   = req_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: scoreboard bench for pipe_mem_arbiter.
// Expected bus transactions are queued when requests are driven.
module tb_pipe_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall;
    logic          bus_err;
    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_ack;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } bus_t;

    bus_t          bus_q[$];
    logic [DW-1:0] res_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_if;
    logic [DW-1:0] exp_mem;

    pipe_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .bus_err   (bus_err),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a request, then compare it with the queue head.
    task automatic wait_req(output bit ok);
        bus_t e;
        int   n = 0;
        ok = 1'b0;
        while (!ram_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ram_req) begin
            check("req_wait", 64'(ram_req), 64'd1);
            return;
        end
        if (bus_q.size() == 0) begin
            check("bus_unexpected", 64'(ram_req), 64'd0);
            return;
        end
        e = bus_q.pop_front();
        check("bus_we", 64'(ram_we), 64'(e.we));
        check("bus_addr", 64'(ram_addr), 64'(e.addr));
        check("bus_wdata", 64'(ram_wdata), 64'(e.wdata));
        ok = 1'b1;
    endtask

    // Serve one access: hold off dly cycles, then pulse ack with rd.
    task automatic serve(input int dly, input logic [DW-1:0] rd);
        bit            ok;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        wait_req(ok);
        if (!ok) return;
        a = ram_addr;
        w = ram_wdata;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check("hold_req", 64'(ram_req), 64'd1);
            check("hold_addr", 64'(ram_addr), 64'(a));
            check("hold_wdata", 64'(ram_wdata), 64'(w));
            check("hold_stall", 64'(stall), 64'd1);
        end
        ram_ack   = 1'b1;
        ram_rdata = rd;
        @(negedge clk);
        ram_ack   = 1'b0;
        ram_rdata = '0;
    endtask

    task automatic idle_bus();
        if_req = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected done");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit ok;
        rst_n     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h40;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ram_rdata = '0;
        ram_ack   = 1'b0;
        exp_if    = '0;
        exp_mem   = '0;

        // 1: reset with a pending fetch, then a single fetch.
        @(negedge clk);
        @(negedge clk);
        check("rst_req", 64'(ram_req), 64'd0);
        check("rst_stall", 64'(stall), 64'd1);
        check("rst_err", 64'(bus_err), 64'd0);
        check("rst_ifd", 64'(if_rdata), 64'd0);
        bus_q.push_back('{1'b0, 32'h40, 32'h0});
        res_q.push_back(32'h8C220004);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_req", 64'(ram_req), 64'd1);
        serve(0, 32'h8C220004);
        exp_if = res_q.pop_front();
        check("t1_ifd", 64'(if_rdata), 64'(exp_if));
        check("t1_stall", 64'(stall), 64'd0);
        idle_bus();

        // 2: load and fetch together; MEM goes first.
        if_req   = 1'b1;
        if_addr  = 32'h40;
        mem_rd   = 1'b1;
        mem_addr = 32'h100;
        bus_q.push_back('{1'b0, 32'h100, 32'h0});
        bus_q.push_back('{1'b0, 32'h40, 32'h0});
        res_q.push_back(32'hA5A50001);
        res_q.push_back(32'h00000013);
        serve(0, 32'hA5A50001);
        check("t2_mid_stall", 64'(stall), 64'd1);
        check("t2_mid_req", 64'(ram_req), 64'd0);
        @(negedge clk);
        check("t2_mid_stall2", 64'(stall), 64'd1);
        serve(0, 32'h00000013);
        exp_mem = res_q.pop_front();
        exp_if  = res_q.pop_front();
        check("t2_stall", 64'(stall), 64'd0);
        check("t2_memd", 64'(mem_rdata), 64'(exp_mem));
        check("t2_ifd", 64'(if_rdata), 64'(exp_if));
        idle_bus();

        // 3: store with a slow ack; load data must not move.
        mem_wr    = 1'b1;
        mem_addr  = 32'h200;
        mem_wdata = 32'hDEADBEEF;
        bus_q.push_back('{1'b1, 32'h200, 32'hDEADBEEF});
        serve(5, 32'h12345678);
        check("t3_stall", 64'(stall), 64'd0);
        check("t3_memd", 64'(mem_rdata), 64'(exp_mem));
        idle_bus();

        // 4: no ack -> watchdog fires after TO busy cycles.
        if_req  = 1'b1;
        if_addr = 32'h80;
        bus_q.push_back('{1'b0, 32'h80, 32'h0});
        wait_req(ok);
        for (int i = 0; i < TO - 1; i++) @(negedge clk);
        check("t4_pre_err", 64'(bus_err), 64'd0);
        check("t4_pre_req", 64'(ram_req), 64'd1);
        @(negedge clk);
        check("t4_err", 64'(bus_err), 64'd1);
        check("t4_req", 64'(ram_req), 64'd0);
        check("t4_stall", 64'(stall), 64'd1);
        if_req    = 1'b0;
        ram_ack   = 1'b1;
        ram_rdata = 32'hFFFF0000;
        @(negedge clk);
        ram_ack   = 1'b0;
        ram_rdata = '0;
        @(negedge clk);
        check("t4_late_err", 64'(bus_err), 64'd1);
        check("t4_late_stall", 64'(stall), 64'd1);
        check("t4_late_ifd", 64'(if_rdata), 64'(exp_if));
        check("t4_late_req", 64'(ram_req), 64'd0);
        rst_n = 1'b0;
        #1;
        check("t4_rst_err", 64'(bus_err), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_if  = '0;
        exp_mem = '0;
        @(negedge clk);
        check("t4_after_stall", 64'(stall), 64'd0);

        // 5: reset in the middle of a load, then re-issue.
        mem_rd   = 1'b1;
        mem_addr = 32'h300;
        bus_q.push_back('{1'b0, 32'h300, 32'h0});
        wait_req(ok);
        rst_n = 1'b0;
        #1;
        check("t5_req", 64'(ram_req), 64'd0);
        check("t5_we", 64'(ram_we), 64'd0);
        check("t5_addr", 64'(ram_addr), 64'd0);
        check("t5_memd", 64'(mem_rdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_q.push_back('{1'b0, 32'h300, 32'h0});
        res_q.push_back(32'hCAFEF00D);
        serve(1, 32'hCAFEF00D);
        exp_mem = res_q.pop_front();
        check("t5_memd2", 64'(mem_rdata), 64'(exp_mem));
        check("t5_stall", 64'(stall), 64'd0);
        idle_bus();

        // 6: stray ack while idle changes nothing.
        ram_ack   = 1'b1;
        ram_rdata = 32'h11112222;
        @(negedge clk);
        ram_ack   = 1'b0;
        ram_rdata = '0;
        check("t6_stall", 64'(stall), 64'd0);
        check("t6_req", 64'(ram_req), 64'd0);
        check("t6_memd", 64'(mem_rdata), 64'(exp_mem));
        check("t6_ifd", 64'(if_rdata), 64'(exp_if));
        if_req  = 1'b1;
        if_addr = 32'h44;
        #1;
        check("t6_flag", 64'(stall), 64'd1);
        bus_q.push_back('{1'b0, 32'h44, 32'h0});
        res_q.push_back(32'h00500093);
        serve(2, 32'h00500093);
        exp_if = res_q.pop_front();
        check("t6_ifd2", 64'(if_rdata), 64'(exp_if));
        check("t6_stall2", 64'(stall), 64'd0);
        idle_bus();

        check("bus_q_empty", 64'(bus_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
